// File: rtl/font_rom_arbiter.sv
// FONT_ROM sharing arbiter: port 0 is the real-time pixel path with priority,
// ports 1..N-1 share a round-robin pool protected by a starvation guard.
module font_rom_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 4,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [7:0]                conflict_cnt
);

    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [PW-1:0] PTR_FIRST = PW'(1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_REQ - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic [7:0]         conflict_q, conflict_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [NUM_REQ-1:0] tag_q [ROM_LAT];

    logic               low_pending;
    logic               low_granted;
    logic               override;
    logic [NUM_REQ-1:0] lo_oh;
    logic [PW-1:0]      lo_idx;
    logic [NUM_REQ-1:0] gnt_c;
    logic [ADDR_W-1:0]  win_addr;

    assign low_pending = |req[NUM_REQ-1:1];

    // Round-robin pick: smallest forward distance from rr_ptr wins.
    always_comb begin
        int best_d;
        int d;
        best_d = NUM_REQ;
        d      = 0;
        lo_oh  = '0;
        lo_idx = PTR_FIRST;
        for (int p = 1; p < NUM_REQ; p++) begin
            d = p - int'(rr_ptr_q);
            if (d < 0) begin
                d = d + (NUM_REQ - 1);
            end
            if (req[p] && (d < best_d)) begin
                best_d   = d;
                lo_oh    = '0;
                lo_oh[p] = 1'b1;
                lo_idx   = PW'(p);
            end
        end
    end

    assign override = (STARVE_MAX != 0) && (starve_q == STARVE_TOP)
                      && low_pending;

    always_comb begin
        gnt_c = '0;
        if (RST) begin
            gnt_c = '0;
        end else if (override) begin
            gnt_c = lo_oh;
        end else if (req[0]) begin
            gnt_c[0] = 1'b1;
        end else if (low_pending) begin
            gnt_c = lo_oh;
        end
    end

    assign low_granted = |gnt_c[NUM_REQ-1:1];

    always_comb begin
        win_addr = '0;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (gnt_c[p]) begin
                win_addr = addr[p*ADDR_W +: ADDR_W];
            end
        end
    end

    // The ROM address holds its last granted value across idle cycles.
    assign rom_addr_d = (|gnt_c) ? win_addr : rom_addr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (low_granted) begin
            rr_ptr_d = (lo_idx == PTR_LAST) ? PTR_FIRST : lo_idx + PW'(1);
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (STARVE_MAX == 0) begin
            starve_d = '0;
        end else if (low_granted || !low_pending) begin
            starve_d = '0;
        end else if (starve_q != STARVE_TOP) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (($countones(req) >= 2) && (conflict_q != 8'hFF)) begin
            conflict_d = conflict_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr_q   <= PTR_FIRST;
            starve_q   <= '0;
            conflict_q <= '0;
            rom_addr_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            starve_q   <= starve_d;
            conflict_q <= conflict_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // Grant tags ride alongside the ROM read so rvalid lines up with rom_q.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= gnt_c;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign gnt          = gnt_c;
    assign rom_addr     = rom_addr_d;
    assign rvalid       = tag_q[ROM_LAT-1];
    assign rdata        = rom_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter: priority/starvation, round-robin with
// two-cycle ROM, pure priority with conflict saturation, and reset behaviour.
module tb_font_rom_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] romf(input logic [8:0] a);
        return a[3:0] ^ a[7:4] ^ {3'b000, a[8]} ^ 4'h9;
    endfunction

    // u0: NUM_REQ=2, STARVE_MAX=8, ROM_LAT=1
    logic        rst0;
    logic [1:0]  req0, gnt0, rv0;
    logic [17:0] addr0;
    logic [3:0]  rd0, romq0;
    logic [8:0]  ra0;
    logic [7:0]  cc0;

    font_rom_arbiter #(.NUM_REQ(2), .ADDR_W(9), .DATA_W(4), .ROM_LAT(1),
                       .STARVE_MAX(8)) u0 (
        .CLK(CLK), .RST(rst0), .req(req0), .addr(addr0), .gnt(gnt0),
        .rvalid(rv0), .rdata(rd0), .rom_addr(ra0), .rom_q(romq0),
        .conflict_cnt(cc0));

    always_ff @(posedge CLK) romq0 <= romf(ra0);

    // u1: NUM_REQ=3, STARVE_MAX=8, ROM_LAT=2
    logic        rst1;
    logic [2:0]  req1, gnt1, rv1;
    logic [26:0] addr1;
    logic [3:0]  rd1, romq1, rom1_s;
    logic [8:0]  ra1;
    logic [7:0]  cc1;

    font_rom_arbiter #(.NUM_REQ(3), .ADDR_W(9), .DATA_W(4), .ROM_LAT(2),
                       .STARVE_MAX(8)) u1 (
        .CLK(CLK), .RST(rst1), .req(req1), .addr(addr1), .gnt(gnt1),
        .rvalid(rv1), .rdata(rd1), .rom_addr(ra1), .rom_q(romq1),
        .conflict_cnt(cc1));

    always_ff @(posedge CLK) begin
        rom1_s <= romf(ra1);
        romq1  <= rom1_s;
    end

    // u2: NUM_REQ=2, STARVE_MAX=0, ROM_LAT=1
    logic        rst2;
    logic [1:0]  req2, gnt2, rv2;
    logic [17:0] addr2;
    logic [3:0]  rd2, romq2;
    logic [8:0]  ra2;
    logic [7:0]  cc2;

    font_rom_arbiter #(.NUM_REQ(2), .ADDR_W(9), .DATA_W(4), .ROM_LAT(1),
                       .STARVE_MAX(0)) u2 (
        .CLK(CLK), .RST(rst2), .req(req2), .addr(addr2), .gnt(gnt2),
        .rvalid(rv2), .rdata(rd2), .rom_addr(ra2), .rom_q(romq2),
        .conflict_cnt(cc2));

    always_ff @(posedge CLK) romq2 <= romf(ra2);

    logic [1:0] e2, p2;
    logic [2:0] e3;
    logic [2:0] hist3 [$];
    logic [8:0] a3 [3];
    int         hits;

    initial begin
        rst0 = 1'b1; req0 = 2'b11; addr0 = {9'h005, 9'h00A};
        rst1 = 1'b1; req1 = 3'b000; addr1 = {9'h022, 9'h011, 9'h000};
        rst2 = 1'b1; req2 = 2'b00; addr2 = {9'h033, 9'h044};
        a3[0] = 9'h000; a3[1] = 9'h011; a3[2] = 9'h022;

        // Reset state with both ports requesting
        @(negedge CLK); #1;
        chk("rst_gnt", 32'(gnt0), 32'h0);
        chk("rst_rvalid", 32'(rv0), 32'h0);
        chk("rst_romaddr", 32'(ra0), 32'h0);
        chk("rst_conflict", 32'(cc0), 32'h0);
        @(negedge CLK); #1;
        chk("rst_conflict2", 32'(cc0), 32'h0);

        // First cycle after release grants port 0
        @(negedge CLK);
        rst0 = 1'b0;
        #1;
        chk("rel_gnt", 32'(gnt0), 32'h1);
        chk("rel_romaddr", 32'(ra0), 32'h00A);
        @(negedge CLK);
        req0 = 2'b00;
        #1;
        chk("rel_rvalid", 32'(rv0), 32'h1);
        chk("rel_rdata", 32'(rd0), 32'(romf(9'h00A)));
        chk("idle_gnt", 32'(gnt0), 32'h0);
        chk("idle_romaddr_hold", 32'(ra0), 32'h00A);
        chk("conflict_one", 32'(cc0), 32'h1);

        // Single read on port 1
        @(negedge CLK);
        req0 = 2'b10;
        #1;
        chk("single_gnt", 32'(gnt0), 32'h2);
        chk("single_romaddr", 32'(ra0), 32'h005);
        @(negedge CLK);
        req0 = 2'b00;
        #1;
        chk("single_rvalid", 32'(rv0), 32'h2);
        chk("single_rdata", 32'(rd0), 32'(romf(9'h005)));

        // Starvation guard: 8 port-0 grants, then port 1, repeating
        p2 = 2'b00;
        for (int c = 0; c < 27; c++) begin
            @(negedge CLK);
            req0 = 2'b11;
            #1;
            e2 = ((c % 9) == 8) ? 2'b10 : 2'b01;
            chk($sformatf("starve_gnt%0d", c), 32'(gnt0), 32'(e2));
            chk($sformatf("starve_rv%0d", c), 32'(rv0), 32'(p2));
            if (p2 == 2'b10) begin
                chk($sformatf("starve_rd%0d", c), 32'(rd0),
                    32'(romf(9'h005)));
            end else if (p2 == 2'b01) begin
                chk($sformatf("starve_rd%0d", c), 32'(rd0),
                    32'(romf(9'h00A)));
            end
            p2 = e2;
        end

        // Reset asserted while a port-1 read is in flight
        @(negedge CLK);
        req0 = 2'b00;
        @(negedge CLK);
        req0 = 2'b10;
        #1;
        chk("mrst_gnt", 32'(gnt0), 32'h2);
        @(posedge CLK);
        #1;
        rst0 = 1'b1;
        req0 = 2'b00;
        #1;
        chk("mrst_rv_now", 32'(rv0), 32'h0);
        @(negedge CLK); #1;
        chk("mrst_rv_hold", 32'(rv0), 32'h0);
        @(negedge CLK);
        rst0 = 1'b0;
        #1;
        chk("mrst_rv_rel", 32'(rv0), 32'h0);
        chk("mrst_conflict", 32'(cc0), 32'h0);
        @(negedge CLK); #1;
        chk("mrst_rv_after", 32'(rv0), 32'h0);

        // Round-robin across ports 1 and 2 with a two-cycle ROM
        @(negedge CLK);
        rst1 = 1'b0;
        req1 = 3'b110;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            e3 = (c % 2 == 0) ? 3'b010 : 3'b100;
            chk($sformatf("rr_gnt%0d", c), 32'(gnt1), 32'(e3));
            if (c >= 2) begin
                chk($sformatf("rr_rv%0d", c), 32'(rv1), 32'(hist3[c-2]));
                chk($sformatf("rr_rd%0d", c), 32'(rd1),
                    32'(romf(hist3[c-2][1] ? a3[1] : a3[2])));
            end else begin
                chk($sformatf("rr_rv%0d", c), 32'(rv1), 32'h0);
            end
            hist3.push_back(e3);
        end
        chk("rr_conflict", 32'(cc1), 32'h7);
        @(negedge CLK);
        req1 = 3'b010;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            chk($sformatf("rr_single%0d", c), 32'(gnt1), 32'h2);
        end

        // Port 0 jumps in and wins over the pool
        @(negedge CLK);
        req1 = 3'b111;
        #1;
        chk("rr_p0_prio", 32'(gnt1), 32'h1);

        // Pure priority: port 1 never served, conflict count saturates
        @(negedge CLK);
        rst2 = 1'b0;
        req2 = 2'b11;
        hits = 0;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            if (gnt2[1]) hits++;
            if (c == 100) chk("pp_conflict100", 32'(cc2), 32'd100);
        end
        chk("pp_gnt1_hits", 32'(hits), 32'd0);
        chk("pp_gnt0", 32'(gnt2), 32'h1);
        chk("pp_conflict_sat", 32'(cc2), 32'd255);
        chk("pp_rvalid", 32'(rv2), 32'h1);
        chk("pp_rdata", 32'(rd2), 32'(romf(9'h044)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
